// File: rtl/defines.sv
// Shared datapath constants for the channel mux family.
package defines;
  localparam int LENGTH = 8;
endpackage

// File: rtl/mux_arb.sv
// N-to-1 channel mux into one output register, external select or round-robin; 1-cycle latency.
// Backpressure: only the chosen channel sees in_ready, and only when the output register can load.
module mux_arb #(
  parameter int LEN  = defines::LENGTH,
  parameter int N    = 4,
  parameter int MODE = 0,
  localparam int SW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*LEN-1:0]  in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SW-1:0]     sel,
  output logic [LEN-1:0]    out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     grant
);

  logic           load;
  logic           pick_vld;
  logic [SW-1:0]  pick;
  logic           xfer;
  logic [LEN-1:0] ch [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch[i] = in_data[i*LEN +: LEN];
  end

  assign load = !out_valid || out_ready;

  if (MODE == 0) begin : g_ext
    // Out-of-range selects (non power-of-2 N) choose nothing.
    always_comb begin
      pick     = sel;
      pick_vld = (int'(sel) < N);
    end
  end else begin : g_rr
    logic [SW-1:0] ptr;

    // Walk the search order backwards so the earliest hit from ptr is the last one written.
    always_comb begin
      logic [SW:0] s;
      pick     = '0;
      pick_vld = 1'b0;
      s        = '0;
      for (int k = N - 1; k >= 0; k--) begin
        s = {1'b0, ptr} + (SW+1)'(k);
        if (s >= (SW+1)'(N)) s = s - (SW+1)'(N);
        if (in_valid[s[SW-1:0]]) begin
          pick     = s[SW-1:0];
          pick_vld = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        ptr <= '0;
      else if (xfer)
        ptr <= (pick == SW'(N - 1)) ? '0 : pick + 1'b1;
    end
  end

  assign xfer = !rst && load && pick_vld && in_valid[pick];

  always_comb begin
    in_ready = '0;
    if (!rst && load && pick_vld) in_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= ch[pick];
        grant    <= pick;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

endmodule

// File: tb/tb_mux_arb.sv
// Directed vector bench for mux_arb: external-select and round-robin instances plus a 3-channel select instance.
module tb_mux_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m0_data, m1_data;
  logic [3:0]  m0_vld, m0_ir, m1_vld, m1_ir;
  logic [1:0]  m0_sel, m0_g, m1_sel, m1_g;
  logic [7:0]  m0_od, m1_od;
  logic        m0_ov, m0_ordy, m1_ov, m1_ordy;

  logic [23:0] m3_data;
  logic [2:0]  m3_vld, m3_ir;
  logic [1:0]  m3_sel, m3_g;
  logic [7:0]  m3_od;
  logic        m3_ov, m3_ordy;

  mux_arb #(.LEN(8), .N(4), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .in_data(m0_data), .in_valid(m0_vld), .in_ready(m0_ir),
    .sel(m0_sel), .out_data(m0_od), .out_valid(m0_ov), .out_ready(m0_ordy), .grant(m0_g));

  mux_arb #(.LEN(8), .N(4), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .in_data(m1_data), .in_valid(m1_vld), .in_ready(m1_ir),
    .sel(m1_sel), .out_data(m1_od), .out_valid(m1_ov), .out_ready(m1_ordy), .grant(m1_g));

  mux_arb #(.LEN(8), .N(3), .MODE(0)) u_m3 (
    .clk(clk), .rst(rst), .in_data(m3_data), .in_valid(m3_vld), .in_ready(m3_ir),
    .sel(m3_sel), .out_data(m3_od), .out_valid(m3_ov), .out_ready(m3_ordy), .grant(m3_g));

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  g;
  } vec_t;

  vec_t t0 [10];
  vec_t t1 [16];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, check combinational ready, then check registers after the edge.
  task automatic apply(input int m, input int i, input vec_t v);
    if (m == 0) begin
      m0_sel = v.sel; m0_vld = v.vld; m0_data = v.dat; m0_ordy = v.ordy;
    end else begin
      m1_sel = v.sel; m1_vld = v.vld; m1_data = v.dat; m1_ordy = v.ordy;
    end
    #1;
    chk($sformatf("m%0d[%0d] in_ready", m, i), (m == 0) ? {28'd0, m0_ir} : {28'd0, m1_ir}, {28'd0, v.ir});
    @(posedge clk); #1;
    chk($sformatf("m%0d[%0d] out_valid", m, i), (m == 0) ? {31'd0, m0_ov} : {31'd0, m1_ov}, {31'd0, v.ov});
    chk($sformatf("m%0d[%0d] out_data", m, i), (m == 0) ? {24'd0, m0_od} : {24'd0, m1_od}, {24'd0, v.od});
    chk($sformatf("m%0d[%0d] grant", m, i), (m == 0) ? {30'd0, m0_g} : {30'd0, m1_g}, {30'd0, v.g});
  endtask

  initial begin
    //          sel    vld      dat            ordy  ir       ov    od     g
    t0[0] = '{2'd2, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    t0[1] = '{2'd1, 4'b0000, 32'h00007700, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
    t0[2] = '{2'd1, 4'b0010, 32'h00007700, 1'b1, 4'b0010, 1'b1, 8'h77, 2'd1};
    t0[3] = '{2'd3, 4'b0000, 32'h00000000, 1'b1, 4'b1000, 1'b0, 8'h77, 2'd1};
    t0[4] = '{2'd0, 4'b0001, 32'h0000003C, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0};
    t0[5] = '{2'd1, 4'b1111, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    t0[6] = '{2'd2, 4'b1111, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    t0[7] = '{2'd3, 4'b1111, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0};
    t0[8] = '{2'd3, 4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    t0[9] = '{2'd0, 4'b0000, 32'h44332211, 1'b1, 4'b0001, 1'b0, 8'h44, 2'd3};

    t1[0]  = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    t1[1]  = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    t1[2]  = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    t1[3]  = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    t1[4]  = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    t1[5]  = '{2'd0, 4'b0100, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    t1[6]  = '{2'd0, 4'b0011, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    t1[7]  = '{2'd0, 4'b0011, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    t1[8]  = '{2'd0, 4'b0000, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    t1[9]  = '{2'd0, 4'b0000, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    t1[10] = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    t1[11] = '{2'd0, 4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    t1[12] = '{2'd0, 4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    t1[13] = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    t1[14] = '{2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    t1[15] = '{2'd0, 4'b0100, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};

    rst = 1'b1;
    m0_data = '0; m0_vld = '0; m0_sel = '0; m0_ordy = 1'b1;
    m1_data = '0; m1_vld = '0; m1_sel = '0; m1_ordy = 1'b1;
    m3_data = '0; m3_vld = '0; m3_sel = '0; m3_ordy = 1'b1;
    #2;
    chk("reset m0 out_valid", {31'd0, m0_ov}, 32'd0);
    chk("reset m0 out_data", {24'd0, m0_od}, 32'd0);
    chk("reset m0 grant", {30'd0, m0_g}, 32'd0);
    chk("reset m0 in_ready", {28'd0, m0_ir}, 32'd0);
    chk("reset m1 out_valid", {31'd0, m1_ov}, 32'd0);
    chk("reset m1 grant", {30'd0, m1_g}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) apply(0, i, t0[i]);
    m0_vld = '0;
    for (int i = 0; i < 16; i++) apply(1, i, t1[i]);

    // Stall with a word held, then reset between edges.
    m1_vld = '0; m1_ordy = 1'b0;
    @(posedge clk); #1;
    chk("stall held out_valid", {31'd0, m1_ov}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'd0, m1_ov}, 32'd0);
    chk("async rst out_data", {24'd0, m1_od}, 32'd0);
    chk("async rst grant", {30'd0, m1_g}, 32'd0);
    m1_vld = 4'b1111; m1_ordy = 1'b1; m0_sel = 2'd0; m0_vld = 4'b0001;
    #1;
    chk("rst m1 in_ready", {28'd0, m1_ir}, 32'd0);
    chk("rst m0 in_ready", {28'd0, m0_ir}, 32'd0);
    @(posedge clk); #1;
    chk("rst held m1 out_valid", {31'd0, m1_ov}, 32'd0);
    chk("rst held m0 out_valid", {31'd0, m0_ov}, 32'd0);
    #2 rst = 1'b0;
    m0_vld = '0;
    m1_vld = 4'b1010; m1_data = 32'hD0C0B0A0;
    #1;
    chk("post-rst in_ready", {28'd0, m1_ir}, 32'h2);
    @(posedge clk); #1;
    chk("post-rst out_valid", {31'd0, m1_ov}, 32'd1);
    chk("post-rst out_data", {24'd0, m1_od}, 32'hB0);
    chk("post-rst grant", {30'd0, m1_g}, 32'd1);
    m1_vld = '0;

    // Three channels: select 3 is out of range.
    m3_sel = 2'd3; m3_vld = 3'b111; m3_data = 24'h332211; m3_ordy = 1'b1;
    #1;
    chk("n3 sel3 in_ready", {29'd0, m3_ir}, 32'd0);
    @(posedge clk); #1;
    chk("n3 sel3 out_valid", {31'd0, m3_ov}, 32'd0);
    m3_sel = 2'd2;
    #1;
    chk("n3 sel2 in_ready", {29'd0, m3_ir}, 32'h4);
    @(posedge clk); #1;
    chk("n3 sel2 out_valid", {31'd0, m3_ov}, 32'd1);
    chk("n3 sel2 out_data", {24'd0, m3_od}, 32'h33);
    chk("n3 sel2 grant", {30'd0, m3_g}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter LEN, default LENGTH (defines package), data width per channel in bits.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 Local SW = $clog2(N), select/grant index width.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_data  input  N*LEN  packed channels; channel i occupies bits [i*LEN +: LEN].
REQ-008 in_valid  input  N  per-channel valid.
REQ-009 in_ready  output  N  per-channel ready, combinational.
REQ-010 sel  input  SW  channel index, used only when MODE=0.
REQ-011 out_data  output  LEN  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 grant  output  SW  registered index of the channel whose word is in out_data.

Function
REQ-015 The block is a single output register stage: load = !out_valid || out_ready.
REQ-016 At most one in_ready bit is high per cycle, and only for the chosen channel c, with in_ready[c] = load.
REQ-017 A transfer on channel c occurs when in_valid[c] && in_ready[c]; on that edge out_data <= channel c data, grant <= c, out_valid <= 1.
REQ-018 If load is high and no transfer occurs, out_valid <= 0 and out_data/grant hold.
REQ-019 While out_valid && !out_ready, out_data, grant and out_valid hold stable, and all in_ready are 0.
REQ-020 Latency is 1 cycle from input transfer to out_valid; sustained throughput is 1 word/cycle with out_ready held high.
REQ-021 MODE=0: c = sel; in_ready[sel] is independent of in_valid[sel].
REQ-022 MODE=0: if sel >= N (N not a power of 2), no channel is chosen, all in_ready are 0, and no transfer occurs.
REQ-023 MODE=1: a pointer ptr (SW bits) is kept; c = first i with in_valid[i] set, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-024 MODE=1: if no in_valid bit is set, no channel is chosen, all in_ready are 0, and ptr holds.
REQ-025 MODE=1: on a transfer from channel c, ptr <= (c+1) mod N, wrapping N-1 -> 0.
REQ-026 MODE=1: ptr holds when out_valid && !out_ready, so no grant is lost or skipped during a stall.
REQ-027 MODE=1: in_ready[c] is a function of in_valid and ptr only, never of in_data.
REQ-028 Fairness (MODE=1): with all N channels valid continuously and out_ready=1, grants cycle 0,1,..,N-1,0,...

Reset
REQ-029 While rst=1: out_valid=0, out_data=0, grant=0, ptr=0, immediately and independent of clk.
REQ-030 in_ready is 0 while rst=1.
REQ-031 Reset asserted mid-stall discards the held word; after rst deasserts the first transfer behaves as from power-up (MODE=1 search starts at channel 0).

Verification
REQ-032 Use N=4, LEN=8. MODE=0, sel=2, in_valid=4'b0100, ch2=0xA5, out_ready=1 -> in_ready=4'b0100, and the next cycle gives out_valid=1, out_data=0xA5, grant=2.
REQ-033 MODE=0, out_ready=0 for 3 cycles after a load of 0x3C, with sel toggling -> out_data stays 0x3C, out_valid=1, in_ready=0; on out_ready=1 the next word loads the same edge.
REQ-034 MODE=1, in_valid=4'b1111 held, out_ready=1, channel data 0x10..0x13 -> grants 0,1,2,3,0 on consecutive cycles with matching data.
REQ-035 MODE=1, ptr=3, in_valid=4'b0011 -> channel 0 is granted and ptr becomes 1; next cycle channel 1 is granted and ptr becomes 2.
REQ-036 MODE=1, in_valid=0 with out_ready=1 for 2 cycles after a word -> out_valid drops to 0 and ptr is unchanged.
REQ-037 rst pulsed asynchronously between edges while out_valid=1, out_ready=0 -> out_valid, out_data, grant and ptr go to 0 immediately; after release with in_valid=4'b1010 in MODE=1, channel 1 is granted first.
